// File: rtl/if_id_stage.sv
// if_id_stage: RV32I fetch stage with PC, IF/ID pipeline register and saturating stall/flush counters
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IF_IDWrite,
    input  logic               ID_PCSrc,
    input  logic [31:0]        ID_TargetAddr,
    input  logic [31:0]        IF_InstrData,
    input  logic               IF_InstrValid,
    output logic [31:0]        IF_InstrAddr,
    output logic [31:0]        ID_PC,
    output logic [31:0]        ID_PCPlus4,
    output logic [31:0]        ID_Instr,
    output logic               ID_Valid,
    output logic               IF_Stall,
    output logic [COUNT_W-1:0] StallCount,
    output logic [COUNT_W-1:0] FlushCount
);
    logic [31:0] pc;
    logic        redirect;
    logic        accept;
    logic        loadBubble;

    // A redirect is only trusted once the hazard unit lets the PC move
    assign redirect     = ID_PCSrc & PCWrite;
    assign accept       = PCWrite & IF_InstrValid;
    assign loadBubble   = redirect | (IF_IDWrite & ~accept);
    assign IF_InstrAddr = pc;
    assign IF_Stall     = ~IF_InstrValid & ~redirect;

    // Program counter: reset, redirect to word-aligned target, or advance on an accepted fetch
    always_ff @(posedge clk) begin
        if (reset)
            pc <= {RESET_PC[31:2], 2'b00};
        else if (redirect)
            pc <= {ID_TargetAddr[31:2], 2'b00};
        else if (accept)
            pc <= pc + 32'd4;
    end

    // IF/ID register: bubble on reset/flush/no-fetch, capture the fetched instruction otherwise
    always_ff @(posedge clk) begin
        if (reset || loadBubble) begin
            ID_PC      <= 32'd0;
            ID_PCPlus4 <= 32'd4;
            ID_Instr   <= NOP_INSTR;
            ID_Valid   <= 1'b0;
        end else if (IF_IDWrite) begin
            ID_PC      <= pc;
            ID_PCPlus4 <= pc + 32'd4;
            ID_Instr   <= IF_InstrData;
            ID_Valid   <= 1'b1;
        end
    end

    // Performance counters saturate at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && !(&StallCount))
                StallCount <= StallCount + COUNT_W'(1);
            if (redirect && !(&FlushCount))
                FlushCount <= FlushCount + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage against a cycle-level reference model
module tb_if_id_stage;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b0;
    logic        IF_IDWrite = 1'b0;
    logic        ID_PCSrc = 1'b0;
    logic [31:0] ID_TargetAddr = '0;
    logic [31:0] IF_InstrData = '0;
    logic        IF_InstrValid = 1'b0;
    logic [31:0] IF_InstrAddr, ID_PC, ID_PCPlus4, ID_Instr;
    logic        ID_Valid, IF_Stall;
    logic [15:0] StallCount, FlushCount;

    if_id_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
        .ID_PCSrc(ID_PCSrc), .ID_TargetAddr(ID_TargetAddr), .IF_InstrData(IF_InstrData),
        .IF_InstrValid(IF_InstrValid), .IF_InstrAddr(IF_InstrAddr), .ID_PC(ID_PC),
        .ID_PCPlus4(ID_PCPlus4), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid),
        .IF_Stall(IF_Stall), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, idPc, idPc4, instr;
        logic        valid, stall;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t expQ[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] mPc = '0, mIdPc = '0, mIdInstr = 32'h13;
    logic        mValid = 1'b0;
    int          mStall = 0, mFlush = 0;

    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic bubble();
        mIdPc = 32'd0;
        mIdInstr = 32'h13;
        mValid = 1'b0;
    endtask

    task automatic step(input logic r, input logic pw, input logic iw, input logic src,
                        input logic [31:0] tgt, input logic iv);
        exp_t e;
        @(negedge clk);
        reset = r; PCWrite = pw; IF_IDWrite = iw; ID_PCSrc = src;
        ID_TargetAddr = tgt; IF_InstrValid = iv;
        IF_InstrData = iv ? instrAt(mPc) : $urandom;
        e.stall = !iv && !(src && pw);
        if (r) begin
            mPc = 32'h0; bubble(); mStall = 0; mFlush = 0;
        end else if (src && pw) begin
            mPc = tgt & ~32'd3; bubble(); mFlush = (mFlush < CMAX) ? mFlush + 1 : CMAX;
        end else if (!pw) begin
            if (iw) bubble();
            mStall = (mStall < CMAX) ? mStall + 1 : CMAX;
        end else if (iv) begin
            if (iw) begin
                mIdPc = mPc; mIdInstr = IF_InstrData; mValid = 1'b1;
            end
            mPc = mPc + 32'd4;
        end else if (iw) begin
            bubble();
        end
        e.addr = mPc; e.idPc = mIdPc; e.idPc4 = mIdPc + 32'd4; e.instr = mIdInstr;
        e.valid = mValid; e.sc = mStall[15:0]; e.fc = mFlush[15:0];
        expQ.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a new state; pop and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("IF_InstrAddr", IF_InstrAddr, e.addr);
                chk("ID_PC", ID_PC, e.idPc);
                chk("ID_PCPlus4", ID_PCPlus4, e.idPc4);
                chk("ID_Instr", ID_Instr, e.instr);
                chk("ID_Valid", {31'd0, ID_Valid}, {31'd0, e.valid});
                chk("IF_Stall", {31'd0, IF_Stall}, {31'd0, e.stall});
                chk("StallCount", {16'd0, StallCount}, {16'd0, e.sc});
                chk("FlushCount", {16'd0, FlushCount}, {16'd0, e.fc});
            end
        end
    end

    initial begin
        logic pw, iw;
        // 1: reset then valid fetch from 0
        step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0, 0, 1);
        // 2: load-use stall at PC 0x10 for two cycles, then resume
        repeat (2) step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 1, 1, 0, 0, 1);
        // 3: redirect from 0x20 to misaligned 0x103
        step(0, 1, 1, 1, 32'h103, 1);
        repeat (2) step(0, 1, 1, 0, 0, 1);
        // 4: redirect ignored while PCWrite=0, taken next cycle
        step(0, 0, 0, 1, 32'h200, 1);
        step(0, 1, 1, 1, 32'h200, 1);
        step(0, 1, 1, 0, 0, 1);
        // 5: three cycles of memory wait
        repeat (3) step(0, 1, 1, 0, 0, 0);
        repeat (2) step(0, 1, 1, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            pw = ($urandom_range(99) < 80);
            iw = ($urandom_range(99) < 90) ? pw : 1'($urandom);
            step($urandom_range(99) < 2, pw, iw, $urandom_range(99) < 15,
                 $urandom, $urandom_range(99) < 80);
        end
        // 6: saturate StallCount, then reset mid-stall
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65536 + 5; i++) step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 32'h40, 1);
        repeat (3) step(0, 1, 1, 0, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expected entries left, 0 required", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
